// File: rtl/gx4000_spr_pkg.sv
// Shared types and constants for the Plus/GX4000 sprite pattern RAM loader.
// Sprite RAM is 16 sprites x 16x16 pixels x 4 bpp = 4096 nibbles, mapped
// into the CPU space at 4000h-4FFFh when the ASIC page is unlocked.
package gx4000_spr_pkg;

  localparam logic [3:0] SPR_BASE_NIB = 4'h4;
  localparam int         SPR_ADDR_W   = 12;

  typedef struct packed {
    logic [11:0] addr;
    logic [3:0]  nib;
  } spr_wr_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_ISSUE,
    RD_DATA
  } rd_state_t;

  // CPU access hits sprite RAM only with Plus features present and the
  // ASIC register page mapped in.
  function automatic logic spr_sel(input logic        plus_mode,
                                   input logic        asic_unlocked,
                                   input logic [15:0] addr);
    return plus_mode & asic_unlocked & (addr[15:12] == SPR_BASE_NIB);
  endfunction

endpackage

// File: rtl/gx4000_spr_fifo.sv
// Single-clock FIFO holding pending sprite RAM writes.
// Ports:
//   clk_sys, reset  : clock, synchronous active-high reset (empties FIFO)
//   push, din       : enqueue one entry (ignored when full)
//   pop             : dequeue the head entry (ignored when empty)
//   full, empty     : occupancy flags, derived from the pointers only
//   dout            : current head entry, valid while !empty
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
module gx4000_spr_fifo
  import gx4000_spr_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          push,
  input  spr_wr_entry_t din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output spr_wr_entry_t dout
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] PTR_ONE = 1;

  logic [IDX_W:0] wr_ptr;
  logic [IDX_W:0] rd_ptr;
  spr_wr_entry_t  mem [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is data only; stale contents are harmless behind the pointers.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= din;
  end

endmodule

// File: rtl/gx4000_sprite_loader.sv
// CPU-side writer/reader for the Plus/GX4000 sprite pattern RAM.
// CPU byte writes to 4000h-4FFFh are buffered and drained into the pattern
// RAM write port only during blanking; CPU reads wait for all buffered
// writes to land before reading the RAM, so readback is coherent.
// Build option: define GX4000_SPRLD_ANYTIME_EN to drain every cycle
// regardless of blanking (debug / early boot, tearing accepted).
// Ports:
//   clk_sys, reset            : clock, synchronous active-high reset
//   plus_mode, asic_unlocked  : decode qualifiers
//   cpu_addr/cpu_data         : CPU address / write data (low nibble used)
//   cpu_wr, cpu_rd            : one-cycle CPU strobes
//   cpu_dout, cpu_dout_valid  : readback byte and its one-cycle strobe
//   busy                      : CPU stall request (read in progress or FIFO full)
//   hblank, vblank            : drain window
//   spr_we/spr_waddr/spr_wdata: pattern RAM write port
//   spr_re/spr_raddr/spr_rdata: pattern RAM read port (data 1 cycle after re)
//   overflow, overflow_clr    : sticky dropped-write flag and its clear
module gx4000_sprite_loader
  import gx4000_spr_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = SPR_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              plus_mode,
  input  logic              asic_unlocked,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_dout,
  output logic              cpu_dout_valid,
  output logic              busy,
  input  logic              hblank,
  input  logic              vblank,
  output logic              spr_we,
  output logic [ADDR_W-1:0] spr_waddr,
  output logic [3:0]        spr_wdata,
  output logic              spr_re,
  output logic [ADDR_W-1:0] spr_raddr,
  input  logic [3:0]        spr_rdata,
  output logic              overflow,
  input  logic              overflow_clr
);

  logic          sel;
  logic          win;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          drop;
  logic          pop;
  spr_wr_entry_t push_entry;
  spr_wr_entry_t head;

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic              rd_latch;
  logic [ADDR_W-1:0] rd_addr;

  logic unused_data_hi;
  assign unused_data_hi = ^cpu_data[7:4];

  assign sel = spr_sel(plus_mode, asic_unlocked, cpu_addr);

`ifdef GX4000_SPRLD_ANYTIME_EN
  assign win = 1'b1;
`else
  assign win = hblank | vblank;
`endif

  assign push       = cpu_wr & sel & ~fifo_full;
  assign drop       = cpu_wr & sel & fifo_full;
  // Drain is independent of decode so buffered writes still land after
  // plus_mode or the unlock drops.
  assign pop        = win & ~fifo_empty;
  assign push_entry = '{addr: cpu_addr[11:0], nib: cpu_data[3:0]};

  gx4000_spr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .din     (push_entry),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dout    (head)
  );

  // ---- drain stage: popped head becomes a registered RAM write ----
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      spr_we    <= 1'b0;
      spr_waddr <= '0;
      spr_wdata <= '0;
    end else begin
      spr_we <= pop;
      if (pop) begin
        spr_waddr <= ADDR_W'(head.addr);
        spr_wdata <= head.nib;
      end
    end
  end

  // Set wins over clear when both happen together.
  always_ff @(posedge clk_sys) begin
    if (reset)             overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  // ---- read FSM ----
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_latch  = 1'b0;
    spr_re    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_rd && sel) begin
          rd_latch  = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      // spr_we high means a popped write has not reached the RAM yet.
      RD_WAIT:  if (fifo_empty && !spr_we) state_nxt = RD_ISSUE;
      RD_ISSUE: begin
        spr_re    = 1'b1;
        state_nxt = RD_DATA;
      end
      RD_DATA:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset)         rd_addr <= '0;
    else if (rd_latch) rd_addr <= cpu_addr[ADDR_W-1:0];
  end

  assign spr_raddr = rd_addr;

  // ---- readback stage: RAM data arrives while in RD_DATA ----
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_dout       <= 8'h00;
      cpu_dout_valid <= 1'b0;
    end else begin
      cpu_dout_valid <= (state == RD_DATA);
      if (state == RD_DATA) cpu_dout <= {4'h0, spr_rdata};
    end
  end

  assign busy = (state != IDLE) | fifo_full;

endmodule
